// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared defaults and helpers for the instruction-fetch front end
package if_fetch_unit_pkg;
  localparam int          ADDR_W_DEFAULT   = 11;
  localparam int          DATA_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_unit_fetch_ret_fifo.sv
// rtl/if_fetch_unit_fetch_ret_fifo.sv - DEPTH-entry sync FIFO buffering returned {pc, inst} words
module fetch_ret_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Issue throttling guarantees a slot for every response; a full push means that broke.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) assert (count != CW'(DEPTH));
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC ownership, ROM issue, in-flight tracking and redirect handling
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = ADDR_W_DEFAULT,
  parameter int          DATA_W   = DATA_W_DEFAULT,
  parameter int          DEPTH    = 2,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_inst
);
  logic [31:0]          fetch_pc;
  logic [31:0]          req_pc_q;
  logic                 req_q;
  logic [CW-1:0]        count;
  logic [31:0]          issue_pc;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [31+DATA_W:0]   head;
  int                   occ;

  assign out_valid = (count != '0) && !redirect_valid && !rst;
  assign pop       = out_valid && out_ready;
  assign push      = req_q && !redirect_valid && !rst;
  assign flush     = rst || redirect_valid;
  assign issue_pc  = redirect_valid ? align_pc(redirect_pc) : fetch_pc;
  assign rom_addr  = rst ? RESET_PC[ADDR_W+1:2] : issue_pc[ADDR_W+1:2];

  // Counting the pop frees its slot this cycle, which keeps DEPTH=2 at one word per cycle.
  always_comb begin
    occ   = int'(count) + int'(req_q) - int'(pop);
    issue = !rst && (redirect_valid || (occ < DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
    end else if (issue) begin
      req_q    <= 1'b1;
      req_pc_q <= issue_pc;
      fetch_pc <= issue_pc + 32'd4;
    end else begin
      req_q    <= 1'b0;
    end
  end

  fetch_ret_fifo #(
    .WIDTH (32 + DATA_W),
    .DEPTH (DEPTH)
  ) u_ret_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({req_pc_q, rom_inst}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_pc   = head[31+DATA_W:DATA_W];
  assign out_inst = out_valid ? head[DATA_W-1:0] : DATA_W'(NOP_INST);
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench with a stream-level scoreboard for if_fetch_unit
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [10:0] rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  logic [31:0] exp_pc;
  logic        prev_rst = 1'b1;
  logic [31:0] rom_mem [2048];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial for (int i = 0; i < 2048; i++) rom_mem[i] = i;
  always @(posedge clk) rom_inst <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: accepted words must run contiguously from the last reset/redirect target.
  always @(negedge clk) begin
    if (rst || redirect_valid || prev_rst) begin
      check("quiet_valid", 64'(out_valid), 64'd0);
    end else if (out_valid && out_ready) begin
      check("sb_pc", 64'(out_pc), 64'(exp_pc));
      check("sb_inst", 64'(out_inst), 64'((exp_pc >> 2) & 32'h7FF));
      accepts++;
    end
    if (rst) exp_pc = 32'h0;
    else if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    else if (out_valid && out_ready) exp_pc = exp_pc + 32'd4;
    prev_rst = rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] inst);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_pc"}, 64'(out_pc), 64'(pc));
    check({name, "_inst"}, 64'(out_inst), 64'(inst));
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc();
    #1; check("rst_valid", 64'(out_valid), 64'd0); check("rst_rom_addr", 64'(rom_addr), 64'd0);

    // streaming from reset
    cyc(); rst = 1'b0; #1; check("c0_valid", 64'(out_valid), 64'd0);
    cyc(); #1; check("c1_valid", 64'(out_valid), 64'd0);
    cyc(); #1; expect_out("c2", 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1; expect_out("stream", 32'(4 * k), 32'(k));
    end

    // backpressure for 5 cycles
    cyc(); out_ready = 1'b0; #1; expect_out("bp_start", 32'd16, 32'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check("bp_rom_addr", 64'(rom_addr), 64'd6);
      expect_out("bp_hold", 32'd16, 32'd4);
    end
    cyc(); out_ready = 1'b1; #1; expect_out("bp_rel0", 32'd16, 32'd4);
    cyc(); #1; expect_out("bp_rel1", 32'd20, 32'd5);
    cyc(); #1; expect_out("bp_rel2", 32'd24, 32'd6);

    // redirect with one buffered and one in flight
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("rd_valid", 64'(out_valid), 64'd0); check("rd_rom_addr", 64'(rom_addr), 64'h40);
    cyc(); redirect_valid = 1'b0; #1; check("rd1_valid", 64'(out_valid), 64'd0);
    cyc(); #1; expect_out("rd2", 32'h100, 32'h40);
    cyc(); #1; expect_out("rd3", 32'h104, 32'h41);

    // fill under stall, then back-to-back redirects
    cyc(); out_ready = 1'b0;
    repeat (3) cyc();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(); redirect_pc = 32'h20;
    cyc(); redirect_pc = 32'h40; #1; check("bb_valid", 64'(out_valid), 64'd0);
    cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1; check("bb1_valid", 64'(out_valid), 64'd0);
    cyc(); #1; expect_out("bb2", 32'h40, 32'h10);
    cyc(); #1; expect_out("bb3", 32'h44, 32'h11);

    // misaligned target at the top of the ROM
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h1FFE; #1;
    check("wr_rom_addr", 64'(rom_addr), 64'h7FF);
    cyc(); redirect_valid = 1'b0; #1; check("wr1_rom_addr", 64'(rom_addr), 64'h0);
    cyc(); #1; expect_out("wr2", 32'h1FFC, 32'h7FF);
    cyc(); #1; expect_out("wr3", 32'h2000, 32'h0);

    // reset with a full FIFO
    cyc(); out_ready = 1'b0;
    repeat (3) cyc();
    cyc(); rst = 1'b1; #1;
    check("mr_valid", 64'(out_valid), 64'd0); check("mr_rom_addr", 64'(rom_addr), 64'd0);
    cyc(); rst = 1'b0; out_ready = 1'b1; #1; check("mr1_valid", 64'(out_valid), 64'd0);
    cyc(); #1; check("mr2_valid", 64'(out_valid), 64'd0);
    cyc(); #1; expect_out("mr3", 32'h0, 32'h0);
    repeat (3) cyc();
    check("accepts_enough", 64'(accepts >= 15), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
